// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Out-of-range load values pin to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] mod);
    if (val >= mod) return mod - 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/mod_step.sv
// One counting step of a modulo-N counter: next value and wrap/clamp event flag.
module mod_step
  import counter_pkg::*;
#(
  parameter int MOD      = 20,
  parameter int STEP     = 1,
  parameter int SATURATE = MODE_WRAP,
  parameter int W        = $clog2(MOD)
) (
  input  logic [W-1:0] q,
  input  logic         u_d,
  output logic [W-1:0] nxt,
  output logic         evt
);

  // One extra bit holds Q+STEP and MOD itself without overflow.
  localparam logic [W:0] MOD_X  = (W+1)'(MOD);
  localparam logic [W:0] STEP_X = (W+1)'(STEP);

  logic [W:0] q_x;
  logic [W:0] up_sum;
  logic [W:0] nxt_x;

  assign q_x    = {1'b0, q};
  assign up_sum = q_x + STEP_X;

  always_comb begin
    // NOTE: defaults first so every path assigns nxt_x and evt; no latch is inferred.
    nxt_x = q_x;
    evt   = 1'b0;
    if (u_d) begin
      if (up_sum >= MOD_X) begin
        evt   = 1'b1;
        nxt_x = (SATURATE == MODE_SAT) ? MOD_X - 1'b1 : up_sum - MOD_X;
      end else begin
        nxt_x = up_sum;
      end
    end else begin
      if (q_x < STEP_X) begin
        evt   = 1'b1;
        nxt_x = (SATURATE == MODE_SAT) ? '0 : q_x + MOD_X - STEP_X;
      end else begin
        nxt_x = q_x - STEP_X;
      end
    end
  end

  assign nxt = nxt_x[W-1:0];

endmodule

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, pause, wrap/saturate mode,
// terminal-count flag, wrap event pulse and sticky overflow flag.
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int MOD      = 20,
  parameter int STEP     = 1,
  parameter int SATURATE = MODE_WRAP,
  parameter int W        = $clog2(MOD)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         P_C,
  input  logic         U_D,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  input  logic         OVF_CLR,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         WRAP,
  output logic         OVF
);

  localparam logic [W-1:0] Q_MAX = W'(MOD - 1);

  logic [W-1:0] step_nxt;
  logic         step_evt;
  logic [W-1:0] load_q;

  mod_step #(
    .MOD     (MOD),
    .STEP    (STEP),
    .SATURATE(SATURATE),
    .W       (W)
  ) u_step (
    .q  (Q),
    .u_d(U_D),
    .nxt(step_nxt),
    .evt(step_evt)
  );

  assign load_q = W'(clamp_load(32'(LOAD_VAL), 32'(MOD)));

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      Q    <= '0;
      WRAP <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (OVF_CLR) OVF <= 1'b0;
      if (LOAD) begin
        Q <= load_q;
      end else if (!P_C) begin
        Q <= step_nxt;
        if (step_evt) begin
          WRAP <= 1'b1;
          // A set on the same edge as OVF_CLR overrides the clear above.
          if (SATURATE == MODE_SAT) OVF <= 1'b1;
        end
      end
    end
  end

  assign TC = (U_D && (Q == Q_MAX)) || (!U_D && (Q == '0));

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream and
// are compared against an arithmetic reference model plus directed expectations.
module tb_modn_updown_counter;

  localparam int N = 4;
  localparam int MODS  [N] = '{20, 10, 20, 7};
  localparam int STEPS [N] = '{1, 3, 1, 4};
  localparam int SATS  [N] = '{0, 0, 1, 1};
  localparam int WS    [N] = '{5, 4, 5, 3};

  logic clk, rst, p_c, u_d, load, ovf_clr;
  int   lv [N];

  logic [4:0] lv0, q0;
  logic [3:0] lv1, q1;
  logic [4:0] lv2, q2;
  logic [2:0] lv3, q3;
  logic       tc_obs [N], wrap_obs [N], ovf_obs [N];
  logic [31:0] q_obs [N];

  assign lv0 = 5'(lv[0]);
  assign lv1 = 4'(lv[1]);
  assign lv2 = 5'(lv[2]);
  assign lv3 = 3'(lv[3]);
  assign q_obs[0] = 32'(q0);
  assign q_obs[1] = 32'(q1);
  assign q_obs[2] = 32'(q2);
  assign q_obs[3] = 32'(q3);

  modn_updown_counter u_d0 (
    .CLK(clk), .RST(rst), .P_C(p_c), .U_D(u_d), .LOAD(load), .LOAD_VAL(lv0),
    .OVF_CLR(ovf_clr), .Q(q0), .TC(tc_obs[0]), .WRAP(wrap_obs[0]), .OVF(ovf_obs[0]));

  modn_updown_counter #(.MOD(10), .STEP(3), .SATURATE(0)) u_d1 (
    .CLK(clk), .RST(rst), .P_C(p_c), .U_D(u_d), .LOAD(load), .LOAD_VAL(lv1),
    .OVF_CLR(ovf_clr), .Q(q1), .TC(tc_obs[1]), .WRAP(wrap_obs[1]), .OVF(ovf_obs[1]));

  modn_updown_counter #(.MOD(20), .STEP(1), .SATURATE(1)) u_d2 (
    .CLK(clk), .RST(rst), .P_C(p_c), .U_D(u_d), .LOAD(load), .LOAD_VAL(lv2),
    .OVF_CLR(ovf_clr), .Q(q2), .TC(tc_obs[2]), .WRAP(wrap_obs[2]), .OVF(ovf_obs[2]));

  modn_updown_counter #(.MOD(7), .STEP(4), .SATURATE(1)) u_d3 (
    .CLK(clk), .RST(rst), .P_C(p_c), .U_D(u_d), .LOAD(load), .LOAD_VAL(lv3),
    .OVF_CLR(ovf_clr), .Q(q3), .TC(tc_obs[3]), .WRAP(wrap_obs[3]), .OVF(ovf_obs[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int mq [N];
  bit mwrap [N];
  bit movf [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k] = 0;
      mwrap[k] = 1'b0;
      movf[k] = 1'b0;
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      int q, m, s;
      bit ev;
      q = mq[k];
      m = MODS[k];
      s = STEPS[k];
      ev = 1'b0;
      if (ovf_clr) movf[k] = 1'b0;
      if (load) begin
        mq[k] = (lv[k] >= m) ? m - 1 : lv[k];
        mwrap[k] = 1'b0;
      end else if (p_c) begin
        mwrap[k] = 1'b0;
      end else begin
        if (u_d) begin
          ev = (q + s > m - 1);
          if (SATS[k] != 0) mq[k] = ev ? m - 1 : q + s;
          else              mq[k] = (q + s) % m;
        end else begin
          ev = (q - s < 0);
          if (SATS[k] != 0) mq[k] = ev ? 0 : q - s;
          else              mq[k] = (q - s + m) % m;
        end
        mwrap[k] = ev;
        if (ev && SATS[k] != 0) movf[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      bit exp_tc;
      exp_tc = u_d ? (mq[k] == MODS[k] - 1) : (mq[k] == 0);
      check($sformatf("model.d%0d.Q", k), q_obs[k], mq[k]);
      check($sformatf("model.d%0d.WRAP", k), 32'(wrap_obs[k]), 32'(mwrap[k]));
      check($sformatf("model.d%0d.OVF", k), 32'(ovf_obs[k]), 32'(movf[k]));
      check($sformatf("model.d%0d.TC", k), 32'(tc_obs[k]), 32'(exp_tc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_lv(input int a, input int b, input int c, input int d);
    lv[0] = a; lv[1] = b; lv[2] = c; lv[3] = d;
  endtask

  int exp_q1 [9]    = '{3, 6, 9, 2, 5, 8, 1, 8, 5};
  int exp_wrap1 [9] = '{0, 0, 0, 1, 0, 0, 1, 1, 0};

  initial begin
    rst = 1'b1; p_c = 1'b0; u_d = 1'b1; load = 1'b0; ovf_clr = 1'b0;
    set_lv(0, 0, 0, 0);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Defaults counting up: 0..19 then wraps.
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("up.d0.Q", 32'(q0), i % 20);
      check("up.d0.WRAP", 32'(wrap_obs[0]), 32'(i == 20));
      check("up.d0.TC", 32'(tc_obs[0]), 32'((i % 20) == 19));
    end

    // Load zero, then reverse direction: TC follows U_D without an edge.
    load = 1'b1; set_lv(0, 0, 0, 0);
    tick();
    load = 1'b0;
    check("load0.d0.TC_up", 32'(tc_obs[0]), 0);
    u_d = 1'b0;
    #1;
    check("rev.d0.TC_down", 32'(tc_obs[0]), 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("down.d0.Q", 32'(q0), (20 - i) % 20);
      check("down.d0.WRAP", 32'(wrap_obs[0]), 32'(i == 1));
    end

    // Modulus-10, step-3 instance: up from 0, then down from 1.
    u_d = 1'b1; load = 1'b1; set_lv(0, 0, 0, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) u_d = 1'b0;
      tick();
      check("step3.d1.Q", 32'(q1), exp_q1[i]);
      check("step3.d1.WRAP", 32'(wrap_obs[1]), exp_wrap1[i]);
    end

    // Saturate mode: clamp at 19 pulses WRAP and sets OVF.
    u_d = 1'b1; load = 1'b1; ovf_clr = 1'b1; set_lv(0, 0, 17, 0);
    tick();
    check("sat.d2.load", 32'(q2), 17);
    check("sat.d2.OVF_cleared", 32'(ovf_obs[2]), 0);
    load = 1'b0; ovf_clr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("sat.d2.Q", 32'(q2), (i >= 2) ? 19 : 17 + i);
      check("sat.d2.WRAP", 32'(wrap_obs[2]), 32'(i >= 3));
      check("sat.d2.OVF", 32'(ovf_obs[2]), 32'(i >= 3));
    end
    p_c = 1'b1; ovf_clr = 1'b1;
    tick();
    check("sat.d2.clr_paused", 32'(ovf_obs[2]), 0);
    check("sat.d2.hold", 32'(q2), 19);
    check("sat.d2.WRAP_paused", 32'(wrap_obs[2]), 0);
    ovf_clr = 1'b0;

    // Out-of-range load while paused clamps to MOD-1.
    load = 1'b1; set_lv(31, 15, 31, 7);
    tick();
    check("clamp.d0.Q", 32'(q0), 19);
    check("clamp.d1.Q", 32'(q1), 9);
    check("clamp.d3.Q", 32'(q3), 6);
    check("clamp.d0.WRAP", 32'(wrap_obs[0]), 0);
    load = 1'b0; p_c = 1'b0; ovf_clr = 1'b1;
    tick();
    check("setwins.d2.OVF", 32'(ovf_obs[2]), 1);
    check("setwins.d2.WRAP", 32'(wrap_obs[2]), 1);
    ovf_clr = 1'b0;

    // Asynchronous reset between edges at Q=12.
    load = 1'b1; set_lv(11, 0, 0, 0);
    tick();
    load = 1'b0;
    tick();
    check("arst.d0.before", 32'(q0), 12);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.d0.Q", 32'(q0), 0);
    check("arst.d0.WRAP", 32'(wrap_obs[0]), 0);
    check("arst.d2.OVF", 32'(ovf_obs[2]), 0);
    check_all();
    #1;
    rst = 1'b0;
    tick();
    check("arst.d0.resume", 32'(q0), 1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      p_c     = ($urandom_range(0, 3) == 0);
      u_d     = $urandom_range(0, 1) != 0;
      load    = ($urandom_range(0, 9) == 0);
      ovf_clr = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < N; k++) lv[k] = int'($urandom_range(0, (1 << WS[k]) - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised modulo-N up/down counter, the next generation of the team's fixed mod-20 pause/continue counter. It adds generic modulus and step, a synchronous parallel load, a selectable wrap or saturate mode, a terminal-count flag, a wrap event pulse and a sticky overflow flag. It feeds display and timing logic in the exam-board designs, and instances can be cascaded through TC and WRAP.

Parameters:
MOD, 20, counter modulus; Q ranges over 0..MOD-1; legal values are 2..65536.
STEP, 1, increment/decrement per active cycle; legal values are 1..MOD-1.
SATURATE, 0, 0 = wrap modulo MOD; 1 = clamp at the end value.
W, $clog2(MOD), width of Q; derived, never overridden.

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous, active-high reset
P_C  in  1  1 = pause (hold), 0 = continue counting
U_D  in  1  1 = count up, 0 = count down
LOAD  in  1  synchronous parallel load strobe
LOAD_VAL  in  W  value to load
OVF_CLR  in  1  synchronous clear of the sticky OVF flag
Q  out  W  current count (registered)
TC  out  1  combinational: Q is at the terminal value for the current direction
WRAP  out  1  registered one-cycle pulse marking a wrap or saturation event
OVF  out  1  registered sticky flag set by a saturation event

Behaviour:
- Reset: RST is asynchronous and active-high. While RST=1: Q=0, WRAP=0, OVF=0, regardless of CLK.
- Per-edge priority: RST > LOAD > P_C > count.
- Load: LOAD=1 sets Q to LOAD_VAL on the next edge, even while paused. If LOAD_VAL >= MOD, Q is set to MOD-1. A load never raises WRAP or OVF.
- Pause: P_C=1 with LOAD=0 holds Q, and WRAP=0.
- Up count, wrap mode: nxt = Q+STEP, computed at W+1 bits. If nxt >= MOD, Q <= nxt-MOD and WRAP=1; otherwise Q <= nxt.
- Down count, wrap mode: if Q < STEP, Q <= Q+MOD-STEP and WRAP=1; otherwise Q <= Q-STEP.
- Saturate mode, up: if Q+STEP > MOD-1, Q <= MOD-1.
- Saturate mode, down: if Q < STEP, Q <= 0.
- Saturate mode, event rule: WRAP=1 and OVF is set only when the clamp actually discards a step. Holding at the end value while counting toward it re-pulses WRAP every active cycle.
- WRAP timing: WRAP rises on the same edge that updates Q, so it is visible together with the new Q. It is high for exactly one cycle per event and deasserts on the next edge unless a new event occurs.
- TC: TC = (U_D & Q==MOD-1) | (~U_D & Q==0). It is purely combinational from Q and U_D, so it follows a U_D change in the same cycle.
- OVF_CLR: clears OVF on the next edge. If a saturation event occurs on the same edge, OVF ends up 1 (set wins). OVF is always 0 when SATURATE=0.
- Direction change: U_D is sampled every edge. There is no extra latency or glitch on a reversal.
- Q never leaves 0..MOD-1, including non-power-of-two MOD.
- With defaults (MOD=20, STEP=1, SATURATE=0) and LOAD=OVF_CLR=0, Q is cycle-identical to the existing mod-20 counter.

Decomposition:
- Shared package counter_pkg holds:
  - the mode constants MODE_WRAP=0 and MODE_SAT=1;
  - a function clamp_load(val, mod).
- One sub-module, mod_step, is natural. It is combinational: inputs Q, U_D, SATURATE; outputs next value and event flag. It isolates the W+1-bit modular arithmetic so that it can be unit-tested exhaustively for small MOD.

Test Plan:
- Defaults, U_D=1, 25 active cycles from reset -> Q 0..19, then 0..4; WRAP high exactly in the cycle Q=0 after 19; TC=1 while Q=19.
- Defaults, U_D=0 from Q=0 -> Q=19, 18, ...; WRAP pulses once on 0->19; TC=1 while Q=0.
- MOD=10, STEP=3, wrap mode, up from 0 -> 3, 6, 9, 2 (WRAP), 5, 8, 1 (WRAP); switch to down at Q=1 -> 8 (WRAP), 5.
- MOD=20, SATURATE=1, LOAD_VAL=17, up -> 17, 18, 19, 19, 19; WRAP=1 on each clamped cycle; OVF stays 1. OVF_CLR with P_C=1 -> OVF=0.
- LOAD_VAL=31 with MOD=20 -> Q=19. LOAD asserted together with P_C=1 -> the load still occurs. OVF_CLR on the same edge as a saturation event -> OVF=1.
- RST pulsed asynchronously mid-count, between edges, at Q=12 -> Q=0, WRAP=0, OVF=0 immediately. Counting resumes from 0 on the first edge after RST falls.
